// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: free-running Fibonacci LFSR with reseed/zero guard feeding a burst FSM over valid/ready.
// Define LFSR_RANGE_REJECT_EN to reject candidates above MAX_VAL; undefined emits raw lfsr[OUT_W-1:0].
module lfsr_rand_gen #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'hB8,
    parameter logic [WIDTH-1:0] SEED = 8'h01,
    parameter int OUT_W = 4,
    parameter int MAX_VAL = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [7:0]       count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;
`ifdef LFSR_RANGE_REJECT_EN
    localparam bit REJECT = 1'b1;
`else
    localparam bit REJECT = 1'b0;
`endif
    localparam logic [OUT_W-1:0] MAX_V = OUT_W'(MAX_VAL);
    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [7:0]       remaining;
    logic [OUT_W-1:0] cand;
    logic             accept;
    assign cand   = lfsr[OUT_W-1:0];
    assign accept = !REJECT || cand <= MAX_V;
    assign busy   = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            // reseed wins over stepping; a zero seed or zero state falls back to SEED
            lfsr <= seed_load ? (seed_in != '0 ? seed_in : SEED)
                  : (lfsr == '0 ? SEED : {lfsr[WIDTH-2:0], ^(lfsr & TAPS)});
            done <= 1'b0;
            case (state)
                IDLE: if (req && count != 8'd0) begin
                    remaining <= count;
                    state     <= GEN;
                end
                GEN: if (accept) begin
                    out_data  <= cand;
                    out_last  <= remaining == 8'd1;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    remaining <= remaining - 8'd1;
                    done      <= remaining == 8'd1;
                    state     <= remaining == 8'd1 ? IDLE : GEN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
